if_id_stage: RTL

- Instruction-fetch and IF/ID register stage, directly downstream of the program-counter block.
- Takes the word-addressed fetch PC and runs a req/ack handshake with a variable-latency instruction memory.
- Holds the fetched instruction in a one-entry skid buffer when decode stalls, then presents it to decode with its PC.
- Pre-decodes the latched opcode and drives the stop_d control the PC block consumes.

---
 rtl/if_id_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch handshake against a variable-latency memory,
// one-entry skid buffer and IF/ID register with opcode pre-decode for the PC block.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module if_id_stage #(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] pc_fetch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_id,
    input  logic        flush,
    output logic [31:0] ir_id,
    output logic [31:0] pc_id,
    output logic        valid_id,
    output logic [1:0]  stop_d,
    output logic [25:0] addr_d,
    output logic        halted,
    output logic        err_timeout
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_HALT} state_t;

    localparam logic [5:0] OP_JUMP = 6'd40;
    localparam logic [5:0] OP_HALT = 6'd63;
    localparam logic [3:0] TO_LAST = 4'(IMEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_id_q, ir_id_d, pc_id_q, pc_id_d;
    logic [31:0] skid_ir_q, skid_ir_d, skid_pc_q, skid_pc_d;
    logic        valid_id_q, valid_id_d;
    logic        pend_q, pend_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [3:0]  to_cnt_q, to_cnt_d;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;
`endif

    logic        in_fetch, do_flush, accept, capture, release_skid, load;
    logic [31:0] load_ir, load_pc;
    logic [1:0]  stop_int;

    // Jump or branch opcodes that need a one-shot redirect/pending indication.
    function automatic logic is_ctl(input logic [5:0] op);
        return op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd42};
    endfunction

    // Handshake qualifiers: what enters IF/ID or the skid this cycle.
    always_comb begin
        in_fetch     = (state_q == S_REQ) || (state_q == S_WAIT);
        do_flush     = flush && (state_q != S_HALT);
        accept       = in_fetch && imem_ack && !stall_id && !flush;
        capture      = in_fetch && imem_ack && stall_id && !flush;
        release_skid = (state_q == S_FULL) && !stall_id && !flush;
        load         = accept || release_skid;
        load_ir      = accept ? imem_rdata : skid_ir_q;
        load_pc      = accept ? pc_fetch : skid_pc_q;
    end

    // PC control: hold unless a fetch completes; a pending jump/branch is
    // reported once, on the first cycle the PC is actually free to move.
    always_comb begin
        stop_int = 2'b10;
        if (accept) begin
            if (valid_id_q && pend_q && (ir_id_q[31:26] == OP_JUMP)) stop_int = 2'b01;
            else if (valid_id_q && pend_q)                          stop_int = 2'b11;
            else                                                    stop_int = 2'b00;
        end
    end

    // Fetch state machine next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ, S_WAIT: begin
                if (flush)         state_d = S_REQ;
                else if (imem_ack) state_d = stall_id ? S_FULL : S_REQ;
                else               state_d = S_WAIT;
            end
            S_FULL:  if (flush || !stall_id) state_d = S_REQ;
            default: state_d = S_HALT;
        endcase
        if (load && (load_ir[31:26] == OP_HALT)) state_d = S_HALT;
    end

    // IF/ID register, skid buffer, pre-decode flags and fetch timeout.
    always_comb begin
        ir_id_d    = ir_id_q;
        pc_id_d    = pc_id_q;
        valid_id_d = valid_id_q;
        pend_d     = pend_q;
        halted_d   = halted_q;
        skid_ir_d  = skid_ir_q;
        skid_pc_d  = skid_pc_q;
        to_cnt_d   = '0;
        err_d      = 1'b0;
        if (do_flush) begin
            valid_id_d = 1'b0;
            pend_d     = 1'b0;
        end else if (load) begin
            ir_id_d    = load_ir;
            pc_id_d    = load_pc;
            valid_id_d = 1'b1;
            pend_d     = is_ctl(load_ir[31:26]);
            halted_d   = halted_q || (load_ir[31:26] == OP_HALT);
        end else if (!stall_id) begin
            valid_id_d = 1'b0;
            pend_d     = 1'b0;
        end
        if (capture) begin
            skid_ir_d = imem_rdata;
            skid_pc_d = pc_fetch;
        end
        // The request stays up after a timeout; only the counter restarts.
        if ((state_q == S_WAIT) && !imem_ack && !flush) begin
            if (to_cnt_q == TO_LAST) err_d    = 1'b1;
            else                     to_cnt_d = to_cnt_q + 4'd1;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters, free-running and wrapping.
    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, (accept || capture)};
        perf_stall_d   = perf_stall_q + {31'd0, ((stop_int == 2'b10) && (state_q != S_HALT))};
    end
`endif

    // State and data registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q        <= S_REQ;
            ir_id_q        <= '0;
            pc_id_q        <= '0;
            skid_ir_q      <= '0;
            skid_pc_q      <= '0;
            valid_id_q     <= 1'b0;
            pend_q         <= 1'b0;
            halted_q       <= 1'b0;
            err_q          <= 1'b0;
            to_cnt_q       <= '0;
`ifdef FETCH_PERF_EN
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ir_id_q        <= ir_id_d;
            pc_id_q        <= pc_id_d;
            skid_ir_q      <= skid_ir_d;
            skid_pc_q      <= skid_pc_d;
            valid_id_q     <= valid_id_d;
            pend_q         <= pend_d;
            halted_q       <= halted_d;
            err_q          <= err_d;
            to_cnt_q       <= to_cnt_d;
`ifdef FETCH_PERF_EN
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
`endif
        end
    end

    // Outputs; request and PC control are forced idle while reset is held.
    always_comb begin
        imem_req    = rstd && in_fetch;
        imem_addr   = pc_fetch;
        stop_d      = rstd ? stop_int : 2'b10;
        ir_id       = ir_id_q;
        pc_id       = pc_id_q;
        valid_id    = valid_id_q;
        addr_d      = ir_id_q[25:0];
        halted      = halted_q;
        err_timeout = err_q;
`ifdef FETCH_PERF_EN
        perf_fetched = perf_fetched_q;
        perf_stall   = perf_stall_q;
`endif
    end

endmodule
